bus_host_arbiter: RTL

- Shares the single request/grant bus-host port (the port feeding the TL-UL host adapter into the main crossbar) between NumReq independent requesters, e.g. the UART bridge and a future boot/DMA sequencer.
- Arbitrates round-robin and holds the winner stable until it is granted.
- Tracks outstanding transactions in order, so each response (valid/rdata/err) routes back to the requester that issued it.

---
 rtl/bus_host_arbiter.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/bus_host_arbiter.sv
// rtl/bus_host_arbiter.sv - shares one request/grant bus-host port between NumReq requesters
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   host_req_i/host_gnt_o  per-requester request / grant
//   host_we_i/be_i/addr_i/wdata_i  per-requester command fields, requester i at slice i
//   host_valid_o           per-requester response valid
//   host_rdata_o/err_o     response data / error, broadcast to all requesters
//   dev_req_o/dev_gnt_i    downstream request / grant
//   dev_we_o/be_o/addr_o/wdata_o   command fields of the selected requester
//   dev_valid_i/rdata_i/err_i      downstream response
//   busy_o                 any transaction outstanding
//   unexp_rsp_o            sticky: response seen with nothing outstanding
//
// Build option: BUS_HOST_ARB_FIXED_PRIO_EN selects fixed lowest-index priority
// instead of round-robin arbitration.

module bus_host_arbiter_id_fifo #(
  parameter int Depth = 2,
  parameter int Width = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic [Width-1:0]           push_data_i,
  input  logic                       pop_i,
  output logic [Width-1:0]           head_o,
  output logic [$clog2(Depth+1)-1:0] count_o
);
  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wr_ptr;
  logic [PtrW-1:0]  rd_ptr;

  // Pointers wrap modulo Depth, which need not be a power of two.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_o <= '0;
      for (int i = 0; i < Depth; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push_i) begin
        mem[wr_ptr] <= push_data_i;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop_i) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({push_i, pop_i})
        2'b10:   count_o <= count_o + CntW'(1);
        2'b01:   count_o <= count_o - CntW'(1);
        default: count_o <= count_o;
      endcase
    end
  end

  assign head_o = mem[rd_ptr];

endmodule

module bus_host_arbiter #(
  parameter int NumReq         = 2,
  parameter int DataWidth      = 32,
  parameter int MaxOutstanding = 2
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [NumReq-1:0]           host_req_i,
  output logic [NumReq-1:0]           host_gnt_o,
  input  logic [NumReq-1:0]           host_we_i,
  input  logic [NumReq*DataWidth/8-1:0] host_be_i,
  input  logic [NumReq*DataWidth-1:0] host_addr_i,
  input  logic [NumReq*DataWidth-1:0] host_wdata_i,
  output logic [NumReq-1:0]           host_valid_o,
  output logic [DataWidth-1:0]        host_rdata_o,
  output logic                        host_err_o,
  output logic                        dev_req_o,
  input  logic                        dev_gnt_i,
  output logic                        dev_we_o,
  output logic [DataWidth/8-1:0]      dev_be_o,
  output logic [DataWidth-1:0]        dev_addr_o,
  output logic [DataWidth-1:0]        dev_wdata_o,
  input  logic                        dev_valid_i,
  input  logic [DataWidth-1:0]        dev_rdata_i,
  input  logic                        dev_err_i,
  output logic                        busy_o,
  output logic                        unexp_rsp_o
);
  localparam int IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int CntW = $clog2(MaxOutstanding + 1);
  localparam int BeW  = DataWidth / 8;

  typedef enum logic {ARB, WAIT_GNT} state_t;

  state_t          state_q, state_d;
  logic [IdxW-1:0] lock_idx_q;
  logic [IdxW-1:0] arb_sel;
  logic [IdxW-1:0] sel;
  logic [IdxW-1:0] head;
  logic [CntW-1:0] count;
  logic            can_issue;
  logic            handshake;
  logic            rsp_accept;
  logic            unexp_q;

`ifndef BUS_HOST_ARB_FIXED_PRIO_EN
  logic [IdxW-1:0] rr_ptr_q;
  logic [IdxW-1:0] rr_idx;
`endif

  // Issue decisions use the registered count only, so a response arriving in
  // the same cycle never opens a slot early. rst_ni keeps requests quiet
  // while reset is held.
  assign can_issue = rst_ni && (count < CntW'(MaxOutstanding));

  // Candidate winner in ARB. Scanning from the highest offset down lets the
  // lowest offset that requests overwrite the others.
  always_comb begin
    arb_sel = '0;
`ifdef BUS_HOST_ARB_FIXED_PRIO_EN
    for (int k = NumReq - 1; k >= 0; k--) begin
      if (host_req_i[k]) arb_sel = IdxW'(k);
    end
`else
    rr_idx = '0;
    for (int k = NumReq - 1; k >= 0; k--) begin
      rr_idx = IdxW'((int'(rr_ptr_q) + k) % NumReq);
      if (host_req_i[rr_idx]) arb_sel = rr_idx;
    end
`endif
  end

  always_comb begin
    state_d   = state_q;
    sel       = arb_sel;
    dev_req_o = 1'b0;
    case (state_q)
      ARB: begin
        dev_req_o = can_issue && (|host_req_i);
        if (dev_req_o && !dev_gnt_i) state_d = WAIT_GNT;
      end
      WAIT_GNT: begin
        // Winner is frozen; a requester dropping out early releases the lock.
        sel       = lock_idx_q;
        dev_req_o = rst_ni && host_req_i[lock_idx_q];
        if (!host_req_i[lock_idx_q]) state_d = ARB;
      end
      default: state_d = ARB;
    endcase
    if (dev_req_o && dev_gnt_i) state_d = ARB;
  end

  assign handshake  = dev_req_o && dev_gnt_i;
  assign rsp_accept = dev_valid_i && (count != '0);

  // Command fields are zero whenever nothing is being requested.
  always_comb begin
    dev_we_o    = 1'b0;
    dev_be_o    = '0;
    dev_addr_o  = '0;
    dev_wdata_o = '0;
    host_gnt_o  = '0;
    for (int i = 0; i < NumReq; i++) begin
      if (dev_req_o && (sel == IdxW'(i))) begin
        dev_we_o    = host_we_i[i];
        dev_be_o    = host_be_i[i*BeW +: BeW];
        dev_addr_o  = host_addr_i[i*DataWidth +: DataWidth];
        dev_wdata_o = host_wdata_i[i*DataWidth +: DataWidth];
        host_gnt_o[i] = dev_gnt_i;
      end
    end
  end

  always_comb begin
    host_valid_o = '0;
    for (int i = 0; i < NumReq; i++) begin
      host_valid_o[i] = rsp_accept && (head == IdxW'(i));
    end
  end

  assign host_rdata_o = rsp_accept ? dev_rdata_i : '0;
  assign host_err_o   = rsp_accept && dev_err_i;
  assign busy_o       = (count != '0);
  assign unexp_rsp_o  = unexp_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ARB;
      lock_idx_q <= '0;
      unexp_q    <= 1'b0;
`ifndef BUS_HOST_ARB_FIXED_PRIO_EN
      rr_ptr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      if ((state_q == ARB) && (state_d == WAIT_GNT)) lock_idx_q <= sel;
      if (dev_valid_i && (count == '0)) unexp_q <= 1'b1;
`ifndef BUS_HOST_ARB_FIXED_PRIO_EN
      if (handshake) begin
        rr_ptr_q <= (sel == IdxW'(NumReq - 1)) ? '0 : sel + IdxW'(1);
      end
`endif
    end
  end

  // Requester IDs of issued transactions, oldest at the head.
  bus_host_arbiter_id_fifo #(
    .Depth (MaxOutstanding),
    .Width (IdxW)
  ) u_id_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (handshake),
    .push_data_i (sel),
    .pop_i       (rsp_accept),
    .head_o      (head),
    .count_o     (count)
  );

endmodule
